vme_system_arbiter: RTL

- VME slot-1 system controller.
- Arbitrates the four bus-request levels BR3..BR0 and starts the matching BGxIN daisy chain. Supports PRI (fixed-priority) or RRS (round-robin) mode.
- Includes the data-transfer bus timer, which drives BERR* when a cycle gets no DTACK*/BERR* reply.
- Sits in the k30p CPLD beside the per-board requester and drives the backplane through open-drain pins.

---
 rtl/vme_system_arbiter_pkg.sv | 18 +
 rtl/vme_bus_timer.sv | 34 +++
 rtl/vme_system_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/vme_system_arbiter_pkg.sv
// vme_system_arbiter_pkg: shared encodings and level selection for the slot-1 arbiter.
package vme_system_arbiter_pkg;
   localparam logic ACTIVE = 1'b0;
   localparam logic INACTIVE = 1'b1;
   localparam int ARB_MODE_PRI = 0;
   localparam int ARB_MODE_RRS = 1;
   typedef enum logic [1:0] {IDLE, GRANT, OWNED, RELEASE} arb_state_t;
   // req is active high; the candidate scanned first wins, so the loop runs last-to-first
   function automatic logic [1:0] pick_level(input logic [3:0] req, input logic [1:0] ptr,
                                             input logic rrs);
      logic [1:0] lvl;
      pick_level = 2'd0;
      for (int i = 4; i >= 1; i--) begin
         lvl = rrs ? ptr - 2'(i) : 2'(4 - i);
         if (req[lvl]) pick_level = lvl;
      end
   endfunction
endpackage

// File: rtl/vme_bus_timer.sv
// vme_bus_timer: data-transfer bus timer; drives BERR* when a strobe goes unanswered.
module vme_bus_timer
   import vme_system_arbiter_pkg::*;
#(
   parameter int BUS_TIMEOUT = 128,
   parameter int TIMER_WIDTH = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] ds,
   input  logic       dtack,
   input  logic       berr_in,
   output logic       berr_out,
   output logic       timeout
);
   localparam logic [TIMER_WIDTH-1:0] BUS_LAST = TIMER_WIDTH'(BUS_TIMEOUT - 1);
   logic [TIMER_WIDTH-1:0] count;
   logic strobe, waiting, fire;
   assign strobe = ds != 2'b11;
   assign waiting = strobe && dtack && berr_in;
   // terminal count wins over a reply arriving the same clock; berr_out blocks a refire
   assign fire = count == BUS_LAST && berr_out;
   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
         berr_out <= INACTIVE;
         timeout <= 1'b0;
      end else begin
         count <= !waiting ? '0 : count == BUS_LAST ? count : count + 1'b1;
         timeout <= fire;
         berr_out <= fire ? ACTIVE : !strobe ? INACTIVE : berr_out;
      end
   end
endmodule

// File: rtl/vme_system_arbiter.sv
// vme_system_arbiter: VME slot-1 system controller; BR3..BR0 arbitration (PRI or RRS)
// plus the data-transfer bus timer.
module vme_system_arbiter
   import vme_system_arbiter_pkg::*;
#(
   parameter int ARB_MODE    = 0,
   parameter int ARB_TIMEOUT = 32,
   parameter int BUS_TIMEOUT = 128,
   parameter int TIMER_WIDTH = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] vme_bus_request,
   input  logic       vme_bus_busy,
   output logic [3:0] vme_bus_grant_out,
   output logic       vme_bus_clear,
   input  logic [1:0] vme_ds,
   input  logic       vme_dtack,
   input  logic       vme_berr_in,
   output logic       vme_berr_out,
   output logic [1:0] owner_level,
   output logic       bus_owned,
   output logic       bus_timeout
);
   localparam logic [TIMER_WIDTH-1:0] ARB_LAST = TIMER_WIDTH'(ARB_TIMEOUT - 1);
   logic [8:0] meta, synced;
   logic [3:0] req;
   logic bus_free;
   logic [1:0] sel, rr_ptr;
   logic [TIMER_WIDTH-1:0] arb_cnt;
   arb_state_t state;
   assign req = ~synced[8:5];
   assign bus_free = synced[4];
   assign sel = pick_level(req, rr_ptr, ARB_MODE == ARB_MODE_RRS);
   // two-flop synchronisers for every backplane input, idle-high out of reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         meta <= '1;
         synced <= '1;
      end else begin
         meta <= {vme_bus_request, vme_bus_busy, vme_ds, vme_dtack, vme_berr_in};
         synced <= meta;
      end
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         vme_bus_grant_out <= 4'hF;
         vme_bus_clear <= INACTIVE;
         owner_level <= 2'd0;
         rr_ptr <= 2'd0;
         arb_cnt <= '0;
         bus_owned <= 1'b0;
      end else begin
         case (state)
            IDLE: if (|req && bus_free) begin
               owner_level <= sel;
               vme_bus_grant_out <= ~(4'b0001 << sel);
               arb_cnt <= '0;
               state <= GRANT;
            end
            GRANT: if (!bus_free) begin
               vme_bus_grant_out <= 4'hF;
               bus_owned <= 1'b1;
               rr_ptr <= owner_level;
               state <= OWNED;
            end else if (arb_cnt == ARB_LAST) begin
               vme_bus_grant_out <= 4'hF;
               state <= IDLE;
            end else arb_cnt <= arb_cnt + 1'b1;
            // BCLR latches on a higher request and is only dropped when the owner lets go
            OWNED: if (bus_free) begin
               bus_owned <= 1'b0;
               vme_bus_clear <= INACTIVE;
               state <= RELEASE;
            end else if (ARB_MODE == ARB_MODE_PRI && (req >> owner_level) > 4'd1)
               vme_bus_clear <= ACTIVE;
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   vme_bus_timer #(.BUS_TIMEOUT(BUS_TIMEOUT), .TIMER_WIDTH(TIMER_WIDTH)) bus_timer (
      .clock   (clock),
      .reset   (reset),
      .ds      (synced[3:2]),
      .dtack   (synced[1]),
      .berr_in (synced[0]),
      .berr_out(vme_berr_out),
      .timeout (bus_timeout)
   );
endmodule
